// File: rtl/cabin_call_scheduler_if.sv
// Call-source / scheduler bundle: level requests, ack and escalation clear in; grant, timer and flags out.
// Latency: none, wires only.
// Backpressure: none; the master holds req until it is served or cancels it.
interface cabin_call_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int TMR_W = 4
);
    logic [N_REQ-1:0] req;
    logic             ack;
    logic             clear_esc;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timer_en;
    logic [TMR_W-1:0] timer_q;
    logic             timeout;
    logic [N_REQ-1:0] escalate;

    // Call-button logic / attendant panel side
    modport master (
        output req, ack, clear_esc,
        input  grant, busy, timer_en, timer_q, timeout, escalate
    );

    // Scheduler side
    modport slave (
        input  req, ack, clear_esc,
        output grant, busy, timer_en, timer_q, timeout, escalate
    );
endinterface

// File: rtl/cabin_call_scheduler.sv
// Round-robin scheduler sharing one attendant service slot among N_REQ call sources, with timeout escalation.
// Latency: req high before edge k gives grant after edge k; each service is followed by one GAP cycle.
// Backpressure: requests are level-held; unserved sources simply wait, a served call ends on ack, cancel or timeout.
module cabin_call_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TMR_W   = 4,
    parameter int TIMEOUT = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cabin_call_scheduler_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic [TMR_W-1:0] timer_q;
    logic             timer_en_q;
    logic             busy_q;
    logic             timeout_q;
    logic [N_REQ-1:0] escalate_q;
    logic [N_REQ-1:0] escalate_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    int               cand;

    logic             served_req;
    logic             tmr_hit;

    // The granted caller is still holding its button; a drop means cancellation.
    assign served_req = |(bus.req & grant_q);
    assign tmr_hit    = (timer_q == TMR_LAST);

    // Round-robin pick: walk offsets downward so the smallest offset from ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (bus.req[cand[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Escalate next state: clear_esc wipes all, ack clears the served bit, a timeout set wins last.
    always_comb begin
        escalate_d = escalate_q;
        if (bus.clear_esc) begin
            escalate_d = '0;
        end
        if (state_q == SERVE) begin
            if (bus.ack) begin
                escalate_d = escalate_d & ~grant_q;
            end else if (served_req && tmr_hit) begin
                escalate_d = escalate_d | grant_q;
            end
        end
    end

    // Main FSM with registered outputs; reset drops any call in progress without escalating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            timer_en_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            escalate_q <= '0;
        end else begin
            escalate_q <= escalate_d;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q    <= SERVE;
                        grant_q    <= N_REQ'(1) << pick_idx;
                        idx_q      <= pick_idx;
                        timer_q    <= '0;
                        timer_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                SERVE: begin
                    if (bus.ack || !served_req || tmr_hit) begin
                        state_q    <= GAP;
                        grant_q    <= '0;
                        timer_q    <= '0;
                        timer_en_q <= 1'b0;
                        timeout_q  <= !bus.ack && served_req && tmr_hit;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= '0;
                    timer_q    <= '0;
                    timer_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.timer_en = timer_en_q;
    assign bus.timer_q  = timer_q;
    assign bus.timeout  = timeout_q;
    assign bus.escalate = escalate_q;

endmodule
